// File: rtl/keypad_pkg.sv
// Shared types and key constants for the keypad front end.
// No logic of its own: scanner state enum, special key codes, row/col to key mapping.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    // Both inputs are active-high one-hot; result is {row index, col index}.
    function automatic logic [3:0] rc_to_key(input logic [3:0] row_oh, input logic [3:0] col_oh);
        logic [1:0] r;
        logic [1:0] c;
        r = 2'd0;
        c = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (row_oh[i]) r = 2'(i);
            if (col_oh[i]) c = 2'(i);
        end
        return {r, c};
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row-scans a 4x4 keypad, debounces one key at a time, emits a key_valid pulse per press.
// Latency: 2 sync flops plus DEBOUNCE_SCANS scan ticks; no backpressure, pulses are fire-and-forget.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 14,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kp_col_i,
    output logic [3:0] kp_row_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o
);

    localparam int             CW   = $clog2(DEBOUNCE_SCANS + 1) + 1;
    localparam logic [CW-1:0]  DS_C = CW'(DEBOUNCE_SCANS);

    logic [3:0]               col_s1_q, col_s2_q;
    logic [SCAN_DIV_BITS-1:0] div_q;
    scan_state_t              state_q, state_d;
    logic [3:0]               row_q, row_d;
    logic [3:0]               pat_q, pat_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     kv_q, kv_d;
    logic [3:0]               kc_q, kc_d;

    logic          tick;
    logic [3:0]    pat;
    logic [CW-1:0] cnt_inc;

    assign tick    = &div_q;
    assign pat     = ~col_s2_q;
    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
            div_q    <= '0;
            state_q  <= SCAN;
            row_q    <= 4'b1110;
            pat_q    <= 4'h0;
            cnt_q    <= '0;
            kv_q     <= 1'b0;
            kc_q     <= 4'h0;
        end else begin
            col_s1_q <= kp_col_i;
            col_s2_q <= col_s1_q;
            div_q    <= div_q + 1'b1;
            state_q  <= state_d;
            row_q    <= row_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            kv_q     <= kv_d;
            kc_q     <= kc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        kv_d    = 1'b0;
        kc_d    = kc_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    // Multi-column presses are ambiguous, so only a clean one-hot is taken.
                    if ($onehot(pat)) begin
                        pat_d   = pat;
                        cnt_d   = CW'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = {row_q[2:0], row_q[3]};
                    end
                end
                DEBOUNCE: begin
                    if (pat == pat_q) begin
                        if (cnt_inc >= DS_C) begin
                            kv_d    = 1'b1;
                            kc_d    = rc_to_key(~row_q, pat_q);
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (pat == 4'h0) begin
                        if (cnt_inc >= DS_C) begin
                            cnt_d   = '0;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    assign kp_row_o    = row_q;
    assign key_valid_o = kv_q;
    assign key_code_o  = kc_q;

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad front end: assembles 4-digit codes and drives exactly one of enab/disab/eegg on ENTER.
// Latency: command/code_err one clk after key_valid; no backpressure, keys act as they arrive.
module keypad_code_entry
    import keypad_pkg::*;
#(
    parameter int          SCAN_DIV_BITS  = 14,
    parameter int          DEBOUNCE_SCANS = 4,
    parameter logic [15:0] ON_CODE        = 16'h1234,
    parameter logic [15:0] OFF_CODE       = 16'h4321,
    parameter logic [15:0] EGG_CODE       = 16'hABCD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kp_col,
    output logic [3:0] kp_row,
    output logic       enab,
    output logic       disab,
    output logic       eegg,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       code_err
);

    logic [15:0] buf_q, buf_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic [2:0]  cmd_q, cmd_d;
    logic        err_q, err_d;

    keypad_scanner #(
        .SCAN_DIV_BITS  (SCAN_DIV_BITS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk         (clk),
        .reset       (reset),
        .kp_col_i    (kp_col),
        .kp_row_o    (kp_row),
        .key_valid_o (key_valid),
        .key_code_o  (key_code)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_q  <= 16'h0000;
            dcnt_q <= 3'd0;
            cmd_q  <= 3'b000;
            err_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            dcnt_q <= dcnt_d;
            cmd_q  <= cmd_d;
            err_q  <= err_d;
        end
    end

    // cmd bits are {enab, disab, eegg}; compare order sets priority if codes collide.
    always_comb begin
        buf_d  = buf_q;
        dcnt_d = dcnt_q;
        cmd_d  = cmd_q;
        err_d  = 1'b0;
        if (key_valid) begin
            if (key_code == KEY_CLEAR) begin
                buf_d  = 16'h0000;
                dcnt_d = 3'd0;
            end else if (key_code == KEY_ENTER) begin
                buf_d  = 16'h0000;
                dcnt_d = 3'd0;
                if (dcnt_q == 3'd4) begin
                    if (buf_q == ON_CODE)       cmd_d = 3'b100;
                    else if (buf_q == OFF_CODE) cmd_d = 3'b010;
                    else if (buf_q == EGG_CODE) cmd_d = 3'b001;
                    else                        err_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (dcnt_q != 3'd4) begin
                buf_d  = {buf_q[11:0], key_code};
                dcnt_d = dcnt_q + 3'd1;
            end
        end
    end

    assign enab     = cmd_q[2];
    assign disab    = cmd_q[1];
    assign eegg     = cmd_q[0];
    assign code_err = err_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Scoreboarded bench for keypad_code_entry with a fast scan divider and short debounce.
module tb_keypad_code_entry;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] kp_col;
    logic [3:0] kp_row;
    logic       enab, disab, eegg, key_valid, code_err;
    logic [3:0] key_code;

    logic       pressed, glitch;
    logic [1:0] prow, pcol;

    int checks   = 0;
    int failures = 0;

    // Entry format: {key[3:0], enab, disab, eegg, code_err} expected after the key.
    logic [7:0] q[$];

    always #5 clk = ~clk;

    keypad_code_entry #(
        .SCAN_DIV_BITS  (2),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .kp_col    (kp_col),
        .kp_row    (kp_row),
        .enab      (enab),
        .disab     (disab),
        .eegg      (eegg),
        .key_valid (key_valid),
        .key_code  (key_code),
        .code_err  (code_err)
    );

    // Passive keypad: a pressed key shorts its column to its row when that row is driven low.
    always_comb begin
        kp_col = 4'hF;
        if (glitch)
            kp_col = 4'b1101;
        else if (pressed && !kp_row[prow])
            kp_col[pcol] = 1'b0;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

    initial begin : monitor
        logic       pend;
        logic [7:0] cur;
        pend = 1'b0;
        cur  = 8'h00;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("cmd_after_key", 16'({enab, disab, eegg, code_err}), 16'(cur[3:0]));
                pend = 1'b0;
            end else if (code_err) begin
                check("spurious_code_err", 16'(code_err), 16'h0);
            end
            if (key_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_key_valid", 16'(key_valid), 16'h0);
                end else begin
                    cur = q.pop_front();
                    check("key_code", 16'(key_code), 16'(cur[7:4]));
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic press(input logic [7:0] v);
        q.push_back(v);
        prow    = v[7:6];
        pcol    = v[5:4];
        pressed = 1'b1;
        repeat (60) @(negedge clk);
        pressed = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    logic [7:0] tbl[46] = '{
        8'hE0,
        8'h10, 8'h20, 8'h30, 8'h40, 8'hF8,
        8'h48, 8'h38, 8'h28, 8'h18, 8'hF4,
        8'hA4, 8'hB4, 8'hC4, 8'hD4, 8'hF2,
        8'h12, 8'h22, 8'hF3,
        8'h92, 8'h92, 8'h92, 8'h92, 8'hF3,
        8'h12, 8'h22, 8'hE2, 8'h12, 8'h22, 8'h32, 8'h42, 8'hF8,
        8'h48, 8'h38, 8'h28, 8'h18, 8'hF4,
        8'h14, 8'h24, 8'h34, 8'h44, 8'h54, 8'hF8,
        8'h18, 8'h28, 8'h38
    };
    logic [3:0] rot_exp[4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    initial begin : stim
        logic [3:0] r0;
        reset   = 1'b0;
        pressed = 1'b0;
        glitch  = 1'b0;
        prow    = 2'd0;
        pcol    = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_kp_row",    16'(kp_row),    16'hE);
        check("rst_enab",      16'(enab),      16'h0);
        check("rst_disab",     16'(disab),     16'h0);
        check("rst_eegg",      16'(eegg),      16'h0);
        check("rst_key_valid", 16'(key_valid), 16'h0);
        check("rst_key_code",  16'(key_code),  16'h0);
        check("rst_code_err",  16'(code_err),  16'h0);

        reset = 1'b1;
        @(negedge clk);
        check("row_first", 16'(kp_row), 16'hE);
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            check("row_rotate", 16'(kp_row), 16'(rot_exp[i]));
        end

        // Key 5 held ~10 ticks: one pulse only, row frozen on row 1 while held.
        q.push_back(8'h50);
        prow    = 2'd1;
        pcol    = 2'd1;
        pressed = 1'b1;
        repeat (40) @(negedge clk);
        check("row_frozen_held", 16'(kp_row), 16'(4'b1101));
        pressed = 1'b0;
        repeat (20) @(negedge clk);
        r0 = kp_row;
        repeat (4) @(negedge clk);
        check("row_resume", 16'(kp_row), 16'(rotl(r0)));

        // Single-tick column glitch must not produce a key.
        glitch = 1'b1;
        repeat (4) @(negedge clk);
        glitch = 1'b0;
        repeat (12) @(negedge clk);
        r0 = kp_row;
        repeat (4) @(negedge clk);
        check("row_after_glitch", 16'(kp_row), 16'(rotl(r0)));

        foreach (tbl[i]) press(tbl[i]);

        // Reset after 1,2,3 with enab active: everything cleared.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_enab",  16'(enab),  16'h0);
        check("mid_rst_disab", 16'(disab), 16'h0);
        check("mid_rst_eegg",  16'(eegg),  16'h0);
        press(8'h40);
        press(8'hF1);

        repeat (10) @(negedge clk);
        check("queue_drained", 16'(q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
